// File: rtl/subtractor_pkg.sv
// Shared definitions for the carry-lookahead subtractor/adder family:
// default widths, the (g, p) pair and the prefix combine operator.
package subtractor_pkg;

  localparam int WIDTH_DEF = 10;
  localparam int SPLIT_DEF = 5;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t make_gp(input logic g, input logic p);
    gp_t r;
    r.g = g;
    r.p = p;
    return r;
  endfunction

  // Merges a more-significant span (hi) with the span directly below it (lo).
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational N-bit carry-lookahead slice computing x + y_inverted + cin.
// Feeding ~b as y_inverted with cin=1 at the bottom slice gives x - b.
module sub_slice
  import subtractor_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y_inverted,
  input  logic         cin,
  output logic [N-1:0] diff,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  gp_t          acc;

  assign g = x & y_inverted;
  assign p = x ^ y_inverted;

  // acc holds the group (g, p) of bits [i:0]; the carry into bit i+1 follows from it and cin.
  always_comb begin
    c    = '0;
    acc  = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      if (i == 0) acc = make_gp(g[0], p[0]);
      else        acc = gp_combine(make_gp(g[i], p[i]), acc);
      c[i+1] = acc.g | (acc.p & cin);
    end
  end

  assign diff = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/subtractor_pipe.sv
// Two-stage pipelined unsigned subtractor d = a - b with borrow-out and zero flags,
// split at SPLIT bits, with valid/ready handshakes on both sides.
module subtractor_pipe
  import subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SPLIT = SPLIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero
);

  localparam int HI = WIDTH - SPLIT;

  logic             vld_p1;
  logic [SPLIT-1:0] lo_diff_p1;
  logic             carry_p1;
  logic [HI-1:0]    a_hi_p1;
  logic [HI-1:0]    b_hi_p1;

  logic [SPLIT-1:0] lo_diff;
  logic             lo_cout;
  logic [HI-1:0]    hi_diff;
  logic             hi_cout;
  logic [WIDTH-1:0] d_next;

  logic load_p2;
  logic in_fire;
  logic adv_p1;

  assign load_p2  = ~out_valid | out_ready;
  assign in_ready = ~vld_p1 | load_p2;
  assign in_fire  = in_valid & in_ready;
  assign adv_p1   = vld_p1 & load_p2;

  // ---- stage 1: low slice, carry-in fixed at 1 for two's-complement subtract
  sub_slice #(.N(SPLIT)) u_lo (
    .x          (a[SPLIT-1:0]),
    .y_inverted (~b[SPLIT-1:0]),
    .cin        (1'b1),
    .diff       (lo_diff),
    .cout       (lo_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          vld_p1 <= 1'b0;
    else if (in_fire) vld_p1 <= 1'b1;
    else if (adv_p1)  vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      lo_diff_p1 <= lo_diff;
      carry_p1   <= lo_cout;
      a_hi_p1    <= a[WIDTH-1:SPLIT];
      b_hi_p1    <= b[WIDTH-1:SPLIT];
    end
  end

  // ---- stage 2: high slice chained on the registered low-slice carry
  sub_slice #(.N(HI)) u_hi (
    .x          (a_hi_p1),
    .y_inverted (~b_hi_p1),
    .cin        (carry_p1),
    .diff       (hi_diff),
    .cout       (hi_cout)
  );

  assign d_next = {hi_diff, lo_diff_p1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      d         <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
    end else if (load_p2) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        d    <= d_next;
        bout <= ~hi_cout;
        zero <= ~|d_next;
      end
    end
  end

endmodule

// File: tb/tb_subtractor_pipe.sv
// Directed and table-driven bench for subtractor_pipe (WIDTH=10, SPLIT=5).
module tb_subtractor_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] a;
  logic [9:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] d;
  logic       bout;
  logic       zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int a;
    int b;
    int exp_d;
    int exp_bout;
    int exp_zero;
  } vec_t;

  vec_t vecs [8];

  subtractor_pipe #(.WIDTH(10), .SPLIT(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_q[$];
  int expb_q[$];
  int expz_q[$];
  int got_q[$];
  int gotb_q[$];
  int gotz_q[$];

  initial begin
    int ra, rb, seen, cycles;
    bit fire;

    vecs[0] = '{300, 100,  200, 0, 0};
    vecs[1] = '{100, 300,  824, 1, 0};
    vecs[2] = '{0,     1, 1023, 1, 0};
    vecs[3] = '{32,    1,   31, 0, 0};
    vecs[4] = '{517, 517,    0, 0, 1};
    vecs[5] = '{1023,  0, 1023, 0, 0};
    vecs[6] = '{512, 513, 1023, 1, 0};
    vecs[7] = '{0,     0,    0, 0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #3;
    check("reset out_valid", out_valid, 0);
    check("reset d", d, 0);
    check("reset bout", bout, 0);
    check("reset zero", zero, 0);
    step(); step();
    rst = 1'b0;
    step();
    check("in_ready after reset", in_ready, 1);

    // Table vectors, one at a time with latency check.
    foreach (vecs[i]) begin
      a = vecs[i].a[9:0]; b = vecs[i].b[9:0]; in_valid = 1'b1;
      check("vec in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("vec latency1 out_valid", out_valid, 0);
      step();
      check("vec out_valid", out_valid, 1);
      check($sformatf("vec%0d d", i), d, vecs[i].exp_d);
      check($sformatf("vec%0d bout", i), bout, vecs[i].exp_bout);
      check($sformatf("vec%0d zero", i), zero, vecs[i].exp_zero);
      step();
      check("vec drained", out_valid, 0);
    end

    // Back-pressure: three ops with out_ready low.
    out_ready = 1'b0;
    a = 10; b = 3; in_valid = 1'b1;
    step();
    a = 20; b = 5;
    check("bp second accepted", in_ready, 1);
    step();
    a = 30; b = 7;
    for (int k = 0; k < 4; k++) begin
      check("bp in_ready low", in_ready, 0);
      check("bp out_valid held", out_valid, 1);
      check("bp d held", d, 7);
      step();
    end
    out_ready = 1'b1;
    got_q.delete();
    for (int k = 0; k < 6; k++) begin
      #1;
      fire = in_valid & in_ready;
      if (out_valid & out_ready) got_q.push_back(int'(d));
      step();
      if (fire) in_valid = 1'b0;
    end
    check("bp result count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("bp result0", got_q[0], 7);
      check("bp result1", got_q[1], 15);
      check("bp result2", got_q[2], 23);
    end

    // Full throughput: 64 random pairs back-to-back.
    exp_q.delete(); expb_q.delete(); expz_q.delete();
    got_q.delete(); gotb_q.delete(); gotz_q.delete();
    out_ready = 1'b1;
    cycles = 0;
    seen = 0;
    for (int k = 0; k < 66; k++) begin
      if (k < 64) begin
        ra = $urandom_range(0, 1023);
        rb = $urandom_range(0, 1023);
        if (k == 0) begin ra = 5; rb = 700; end
        a = ra[9:0]; b = rb[9:0]; in_valid = 1'b1;
        exp_q.push_back((ra - rb + 1024) % 1024);
        expb_q.push_back(ra < rb ? 1 : 0);
        expz_q.push_back(ra == rb ? 1 : 0);
        if (!in_ready) seen++;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid & out_ready) begin
        got_q.push_back(int'(d));
        gotb_q.push_back(int'(bout));
        gotz_q.push_back(int'(zero));
      end
      step();
      cycles++;
    end
    check("tp in_ready stalls", seen, 0);
    check("tp result count", got_q.size(), 64);
    for (int k = 0; k < 64 && k < got_q.size(); k++) begin
      check($sformatf("tp d[%0d]", k), got_q[k], exp_q[k]);
      check($sformatf("tp bout[%0d]", k), gotb_q[k], expb_q[k]);
      check($sformatf("tp zero[%0d]", k), gotz_q[k], expz_q[k]);
    end

    // Reset with both stages full.
    out_ready = 1'b0;
    a = 9; b = 2; in_valid = 1'b1;
    step();
    a = 4; b = 1;
    step();
    in_valid = 1'b0;
    check("pre-reset full out_valid", out_valid, 1);
    check("pre-reset full in_ready", in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset in_ready", in_ready, 1);
    check("async reset d", d, 0);
    step();
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (out_valid) seen++;
    end
    check("no stale result after reset", seen, 0);
    check("in_ready after reset release", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/subtractor_pipe.md
# subtractor_pipe

Two-stage pipelined unsigned subtractor computing D = A − B with a borrow-out flag. It is the inverse-direction companion to the combinational prefix adder: it reuses the same generate/propagate carry-lookahead formulation on A + ~B + 1. It adds a valid/ready handshake and a pipeline register at the half-word boundary so that it can sit in clocked datapaths.

## Interface
- WIDTH, 10, operand and result width in bits
- SPLIT, 5, width of the low slice computed in stage 1; legal range 1 … WIDTH−1
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair a/b is presented
- in_ready  output  1  block can accept the operand pair this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result d/bout/zero is valid
- out_ready  input  1  consumer accepts the result this cycle
- d  output  WIDTH  (a − b) mod 2^WIDTH
- bout  output  1  1 when a < b (unsigned)
- zero  output  1  1 when d == 0

## Operation
- Subtraction is computed as a + ~b + 1:
  - per-bit p = a ^ ~b and g = a & ~b;
  - carry-lookahead prefix over each slice;
  - carry-in of the low slice is 1.
- Stage 1 (on input handshake in_valid & in_ready):
  - computes the low SPLIT bits of d and the carry out of the low slice;
  - registers that low difference, the slice carry, and the upper WIDTH−SPLIT bits of a and b;
  - sets s1_valid.
- Stage 2 (on advance from stage 1):
  - computes the upper slice using the registered carry as carry-in;
  - registers d = {hi_diff, lo_diff};
  - registers bout = ~carry_out(upper slice);
  - registers zero = (d == 0);
  - sets out_valid.
- Handshake rules:
  - A transfer occurs only when valid and ready are both 1 in the same cycle.
  - out_valid, d, bout and zero hold stable while out_valid & ~out_ready.
  - Stage 2 loads when ~out_valid | out_ready.
  - in_ready = ~s1_valid | stage-2-loads. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Simultaneous events:
  - An input transfer and a stage-1→2 advance in the same cycle both happen; nothing is lost and nothing is duplicated.
  - If stage 1 is emptied and not refilled, s1_valid clears.
- Width rules:
  - Intermediate carries are 1 bit; no sign extension; operands are treated as unsigned.
  - Overflow wraps modulo 2^WIDTH, and the wrap is flagged only through bout.

## Timing
- Latency: a result appears on out_valid 2 cycles after the input handshake edge, when there is no back-pressure.
- Throughput: 1 operation per cycle with out_ready held high.
- Capacity: 2 in-flight operations. With out_ready low, in_ready deasserts once both stages are full.
- Reset (asynchronous, takes effect immediately):
  - out_valid = 0, s1_valid = 0, d = 0, bout = 0, zero = 0;
  - in_ready = 1 from the first cycle after reset release.
- Reset asserted mid-operation discards all in-flight operations; no partial result is emitted.
- Data registers in both stages only load on their enable. Idle cycles do not disturb held outputs.

## Structure
- Shared package subtractor_pkg holds:
  - default WIDTH and SPLIT constants;
  - a function or typedef for the (g, p) pair;
  - the prefix combine operator (g_hi | p_hi & g_lo, p_hi & p_lo), shared with the adder family.
- One sub-module, sub_slice: a combinational N-bit carry-lookahead slice.
  - Inputs x, y_inverted, cin; outputs diff, cout.
  - Instantiated twice: SPLIT bits in stage 1, WIDTH−SPLIT bits in stage 2.
- Top level holds the two pipeline registers and the handshake logic only.

## Test plan
- Basic subtraction: a=300, b=100 with out_ready=1 → two cycles later d=200, bout=0, zero=0.
- Negative result: a=100, b=300 → d=824, bout=1; a=0, b=1 → d=1023, bout=1.
- Borrow across the split: a=32, b=1 → d=31, bout=0 (low-slice carry=0 propagated into stage 2); a=b=517 → d=0, zero=1, bout=0.
- Back-pressure: stream 3 ops (10−3, 20−5, 30−7) with out_ready=0 for 4 cycles:
  - in_ready drops after 2 accepted;
  - d=7 is held stable;
  - after out_ready=1, outputs are 7, 15, 23 in order with no loss or duplicates.
- Full throughput: 64 random pairs with in_valid=1 and out_ready=1 continuously → one result per cycle, each matching (a−b) mod 1024 and a<b.
- Reset mid-stream: assert rst with both stages full → out_valid=0 and in_ready=1 immediately; neither old result ever appears after release.
